// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side client of a byte RAM. On an accepted start it fetches i_len consecutive bytes
//   from i_base, one read at a time, and pushes each returned byte into a small FIFO that is
//   drained over a valid/ready byte stream. A per-read timeout aborts the transfer if the RAM
//   never answers; bytes already queued are still delivered.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start, i_base, i_len    transfer request (sampled only when idle)
//   o_ram_read, o_ram_addr    one-cycle read strobe and its address
//   i_ram_data, i_ram_valid   RAM read return
//   o_data, o_valid, i_ready  output byte stream (FIFO head)
//   o_busy, o_done, o_err     status: not idle, end-of-transfer pulse, sticky timeout
module ram_burst_reader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_ram_read,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [DATA_W-1:0] i_ram_data,
    input  logic              i_ram_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W:0] LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_strobe;
    logic                w_push;
    logic                w_pop;
    logic                w_timeout;
    logic                w_done;
    logic [ADDR_W:0]     w_len;

    assign w_len   = (i_len > LEN_MAX) ? LEN_MAX : i_len;
    assign w_pop   = o_valid & i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_strobe    = 1'b0;
        w_push      = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_len == '0) ? StDrain : StIssue;
                end
            end
            StIssue: begin
                // A free slot now stays free until the answer lands: only one read is in flight.
                if (r_count < CNT_FULL) begin
                    w_strobe    = 1'b1;
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (i_ram_valid) begin
                    w_push      = 1'b1;
                    w_state_nxt = (r_remaining == LEN_ONE) ? StDrain : StIssue;
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (r_count == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_remaining <= '0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_addr      <= i_base;
                r_remaining <= w_len;
                r_err       <= 1'b0;
            end

            // Counter reads 0 on the strobe cycle, so the value in WAIT is cycles since strobe.
            if (w_strobe) begin
                r_tmo <= TMO_W'(1);
            end else if (r_state == StWait) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_push) begin
                r_addr         <= r_addr + ADDR_W'(1);
                r_remaining    <= r_remaining - LEN_ONE;
                r_mem[r_wptr]  <= i_ram_data;
                r_wptr         <= r_wptr + PTR_W'(1);
            end

            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_ram_read = w_strobe;
    assign o_ram_addr = r_addr;
    assign o_data     = r_mem[r_rptr];
    assign o_valid    = (r_count != '0);
    assign o_busy     = (r_state != StIdle);
    assign o_done     = w_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: a one-cycle-latency RAM model that can withhold one
// answer, a negedge monitor that logs strobes, streamed bytes and done pulses, and one task
// per scenario with inline comparisons.
module tb_ram_burst_reader;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_base = 8'h00;
    logic [8:0] i_len = 9'd0;
    logic       o_ram_read;
    logic [7:0] o_ram_addr;
    logic [7:0] i_ram_data = 8'h00;
    logic       i_ram_valid = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] strobe_q [$];
    logic [7:0] data_q [$];
    int         done_cnt = 0;
    int         cyc = 0;
    int         strobe_cyc = 0;
    int         done_cyc = 0;
    logic       busy_at_done = 1'b0;

    int         drop_at = 0;
    logic       inject = 1'b0;
    logic       pend = 1'b0;
    logic [7:0] pend_addr = 8'h00;

    ram_burst_reader #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (4),
        .TIMEOUT(15)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_base     (i_base),
        .i_len      (i_len),
        .o_ram_read (o_ram_read),
        .o_ram_addr (o_ram_addr),
        .i_ram_data (i_ram_data),
        .i_ram_valid(i_ram_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] ram_byte(input logic [7:0] a);
        return a ^ 8'hC3;
    endfunction

    // RAM: answers a strobe in the following cycle unless that strobe number is drop_at.
    always @(posedge i_clk) begin
        #1;
        i_ram_valid = pend | inject;
        i_ram_data  = inject ? 8'hEE : ram_byte(pend_addr);
        pend        = 1'b0;
        if (o_ram_read && (strobe_q.size() + 1 != drop_at)) begin
            pend      = 1'b1;
            pend_addr = o_ram_addr;
        end
    end

    always @(negedge i_clk) begin
        cyc++;
        if (o_ram_read) begin
            strobe_q.push_back(o_ram_addr);
            strobe_cyc = cyc;
        end
        if (o_valid && i_ready) data_q.push_back(o_data);
        if (o_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = o_busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] base, input logic [8:0] len);
        tick(1);
        i_start = 1'b1;
        i_base  = base;
        i_len   = len;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_done: o_done count %0d, required %0d within %0d cycles",
                     done_cnt, target, budget);
        end
        tick(1);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(3);
        i_rst = 1'b0;
        checks++;
        if ({o_busy, o_valid, o_done, o_err, o_ram_read} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/valid/done/err/read = %b, required 00000",
                     {o_busy, o_valid, o_done, o_err, o_ram_read});
        end
        checks++;
        if (o_ram_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h, required 00", o_ram_addr);
        end
        checks++;
        if (o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h, required 00", o_data);
        end
    endtask

    task automatic test_basic();
        int sb, db, dc;
        logic [7:0] a;
        sb = strobe_q.size(); db = data_q.size(); dc = done_cnt;
        i_ready = 1'b1;
        do_start(8'h10, 9'd4);
        wait_done(dc + 1, 200);
        checks++;
        if (strobe_q.size() - sb != 4) begin
            errors++;
            $display("FAIL basic_strobes: got %0d, required 4", strobe_q.size() - sb);
        end
        for (int i = 0; i < 4; i++) begin
            a = 8'h10 + 8'(i);
            checks++;
            if (strobe_q[sb + i] !== a) begin
                errors++;
                $display("FAIL basic_addr[%0d]: got %h, required %h", i, strobe_q[sb + i], a);
            end
            checks++;
            if (data_q[db + i] !== ram_byte(a)) begin
                errors++;
                $display("FAIL basic_data[%0d]: got %h, required %h", i, data_q[db + i],
                         ram_byte(a));
            end
        end
        checks++;
        if (done_cnt - dc != 1 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_err: dones %0d err %b, required 1 and 0",
                     done_cnt - dc, o_err);
        end
        checks++;
        if (busy_at_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: at done %b after %b, required 1 then 0",
                     busy_at_done, o_busy);
        end
    endtask

    task automatic test_wrap();
        int sb, db, dc;
        logic [7:0] exp_a [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        sb = strobe_q.size(); db = data_q.size(); dc = done_cnt;
        i_ready = 1'b1;
        do_start(8'hFE, 9'd4);
        wait_done(dc + 1, 200);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (strobe_q[sb + i] !== exp_a[i] || data_q[db + i] !== ram_byte(exp_a[i])) begin
                errors++;
                $display("FAIL wrap[%0d]: addr %h data %h, required %h %h", i,
                         strobe_q[sb + i], data_q[db + i], exp_a[i], ram_byte(exp_a[i]));
            end
        end
        checks++;
        if (data_q.size() - db != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d bytes, required 4", data_q.size() - db);
        end
    endtask

    task automatic test_backpressure();
        int sb, db, dc;
        logic [7:0] a;
        sb = strobe_q.size(); db = data_q.size(); dc = done_cnt;
        i_ready = 1'b0;
        do_start(8'h20, 9'd6);
        tick(30);
        checks++;
        if (strobe_q.size() - sb != 4 || o_valid !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: strobes %0d valid %b busy %b, required 4 1 1",
                     strobe_q.size() - sb, o_valid, o_busy);
        end
        i_ready = 1'b1;
        wait_done(dc + 1, 200);
        checks++;
        if (strobe_q.size() - sb != 6 || data_q.size() - db != 6) begin
            errors++;
            $display("FAIL bp_totals: strobes %0d bytes %0d, required 6 6",
                     strobe_q.size() - sb, data_q.size() - db);
        end
        for (int i = 0; i < 6; i++) begin
            a = 8'h20 + 8'(i);
            checks++;
            if (data_q[db + i] !== ram_byte(a)) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h, required %h", i, data_q[db + i],
                         ram_byte(a));
            end
        end
    endtask

    task automatic test_timeout();
        int sb, db, dc;
        sb = strobe_q.size(); db = data_q.size(); dc = done_cnt;
        i_ready = 1'b1;
        drop_at = sb + 3;
        do_start(8'h40, 9'd5);
        wait_done(dc + 1, 200);
        tick(5);
        checks++;
        if (o_err !== 1'b1 || done_cnt - dc != 1) begin
            errors++;
            $display("FAIL tmo_err: err %b dones %0d, required 1 1", o_err, done_cnt - dc);
        end
        checks++;
        if (strobe_q.size() - sb != 3 || data_q.size() - db != 2) begin
            errors++;
            $display("FAIL tmo_counts: strobes %0d bytes %0d, required 3 2",
                     strobe_q.size() - sb, data_q.size() - db);
        end
        checks++;
        if (data_q[db] !== ram_byte(8'h40) || data_q[db + 1] !== ram_byte(8'h41)) begin
            errors++;
            $display("FAIL tmo_data: got %h %h, required %h %h", data_q[db], data_q[db + 1],
                     ram_byte(8'h40), ram_byte(8'h41));
        end
        // Strobe at count 0, abort when the counter hits 15, done in the first DRAIN cycle.
        checks++;
        if (done_cyc - strobe_cyc != 16) begin
            errors++;
            $display("FAIL tmo_latency: strobe-to-done %0d cycles, required 16",
                     done_cyc - strobe_cyc);
        end
        drop_at = 0;
        db = data_q.size(); dc = done_cnt;
        do_start(8'h50, 9'd1);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err_clear: got %b, required 0", o_err);
        end
        wait_done(dc + 1, 100);
        checks++;
        if (data_q.size() - db != 1 || data_q[db] !== ram_byte(8'h50)) begin
            errors++;
            $display("FAIL tmo_next: bytes %0d first %h, required 1 %h",
                     data_q.size() - db, data_q[db], ram_byte(8'h50));
        end
    endtask

    task automatic test_len0_and_busy();
        int sb, db, dc;
        sb = strobe_q.size(); dc = done_cnt;
        do_start(8'h30, 9'd0);
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL len0_done: got %b, required 1 one cycle after start", o_done);
        end
        tick(1);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || strobe_q.size() != sb) begin
            errors++;
            $display("FAIL len0_after: done %b busy %b strobes %0d, required 0 0 0",
                     o_done, o_busy, strobe_q.size() - sb);
        end
        sb = strobe_q.size(); db = data_q.size(); dc = done_cnt;
        i_ready = 1'b1;
        do_start(8'h70, 9'd2);
        i_start = 1'b1;
        i_base  = 8'h00;
        i_len   = 9'd9;
        tick(1);
        i_start = 1'b0;
        wait_done(dc + 1, 100);
        tick(3);
        checks++;
        if (strobe_q.size() - sb != 2 || done_cnt - dc != 1) begin
            errors++;
            $display("FAIL busy_start_counts: strobes %0d dones %0d, required 2 1",
                     strobe_q.size() - sb, done_cnt - dc);
        end
        checks++;
        if (strobe_q[sb] !== 8'h70 || strobe_q[sb + 1] !== 8'h71 ||
            data_q[db + 1] !== ram_byte(8'h71)) begin
            errors++;
            $display("FAIL busy_start_addr: %h %h last byte %h, required 70 71 %h",
                     strobe_q[sb], strobe_q[sb + 1], data_q[db + 1], ram_byte(8'h71));
        end
    endtask

    task automatic test_reset_mid();
        int sb, dc, n;
        sb = strobe_q.size(); dc = done_cnt;
        i_ready = 1'b0;
        drop_at = sb + 3;
        do_start(8'h60, 9'd6);
        n = 0;
        while (strobe_q.size() < sb + 3 && n < 50) begin
            tick(1);
            n++;
        end
        tick(2);
        checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b1 || o_data !== ram_byte(8'h60)) begin
            errors++;
            $display("FAIL mid_pre: busy %b valid %b data %h, required 1 1 %h",
                     o_busy, o_valid, o_data, ram_byte(8'h60));
        end
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        checks++;
        if ({o_busy, o_valid, o_done, o_err, o_ram_read} !== 5'b0 || o_ram_addr !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: busy/valid/done/err/read %b addr %h, required 00000 00",
                     {o_busy, o_valid, o_done, o_err, o_ram_read}, o_ram_addr);
        end
        drop_at = 0;
        inject  = 1'b1;
        tick(2);
        inject  = 1'b0;
        tick(3);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || done_cnt != dc) begin
            errors++;
            $display("FAIL mid_late_valid: valid %b busy %b dones %0d, required 0 0 0",
                     o_valid, o_busy, done_cnt - dc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_len0_and_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
